// File: rtl/uart_bcd_bridge.sv
// UART bridge for the board top: baud generator, oversampled RX with parity/frame checks,
// RX FIFO, TX engine (manual stream or FIFO loopback) and an 8-bit display message.
module uart_bcd_bridge #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                            src_clk,
    input  logic                            rst_n,
    input  logic                            cfg_mode,
    input  logic [1:0]                      baud_sel,
    input  logic                            data_dir,
    input  logic                            stream,
    input  logic [DATA_W-1:0]               manual_data,
    input  logic                            send_pulse,
    input  logic                            rx_in,
    output logic                            tx_out,
    output logic                            tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]     rx_count,
    output logic                            rx_overflow,
    output logic                            frame_err,
    output logic                            parity_err,
    output logic [7:0]                      msg
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int OS_W    = $clog2(OVERSAMPLE);
    localparam int BIT_W   = 4;
    localparam int TX_BITS = DATA_W + PARITY_EN + 2;

    function automatic int div_of(input int baud);
        int d;
        d = CLK_HZ / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

    localparam int DIV0  = div_of(9600);
    localparam int DIV1  = div_of(19200);
    localparam int DIV2  = div_of(57600);
    localparam int DIV3  = div_of(115200);
    localparam int DIV_W = $clog2(DIV0 + 1);

    function automatic logic [7:0] to_msg(input logic [DATA_W-1:0] w);
        logic [DATA_W+7:0] ext;
        ext = {8'b0, w};
        return ext[7:0];
    endfunction

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    logic [1:0]         baud_reg;
    logic [DIV_W-1:0]   div_max, div_cnt;
    logic               tick;

    always_comb begin
        div_max = DIV_W'(DIV0 - 1);
        case (baud_reg)
            2'b01:   div_max = DIV_W'(DIV1 - 1);
            2'b10:   div_max = DIV_W'(DIV2 - 1);
            2'b11:   div_max = DIV_W'(DIV3 - 1);
            default: div_max = DIV_W'(DIV0 - 1);
        endcase
    end

    assign tick = (div_cnt == div_max);

    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            baud_reg <= 2'b00;
            div_cnt  <= '0;
        end else begin
            if (cfg_mode) baud_reg <= baud_sel;
            if ((cfg_mode && baud_sel != baud_reg) || tick) div_cnt <= '0;
            else                                            div_cnt <= div_cnt + 1'b1;
        end
    end

    logic               rx_s1, rx_s2, rx_s3, rx_fall;
    rx_state_t          rx_state, rx_next;
    logic [OS_W-1:0]    rx_os, rx_target;
    logic [BIT_W-1:0]   rx_bit;
    logic [DATA_W-1:0]  rx_shift;
    logic               rx_par, rx_sample, stop_sample, parity_ok, push_req, push, pop, full;

    assign rx_fall     = rx_s3 & ~rx_s2;
    assign rx_target   = (rx_state == RX_START) ? OS_W'(OVERSAMPLE/2 - 1) : OS_W'(OVERSAMPLE - 1);
    assign rx_sample   = tick && (rx_os == rx_target);
    assign stop_sample = rx_sample && (rx_state == RX_STOP) && !cfg_mode;
    assign parity_ok   = (PARITY_EN == 0) || (rx_par == ((^rx_shift) ^ (PARITY_ODD != 0)));
    assign push_req    = stop_sample && rx_s2 && parity_ok;
    assign push        = push_req && (!full || pop);

    always_comb begin
        rx_next = rx_state;
        if (cfg_mode) begin
            rx_next = RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE:   if (rx_fall) rx_next = RX_START;
                RX_START:  if (rx_sample) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
                RX_DATA:   if (rx_sample && rx_bit == BIT_W'(DATA_W - 1))
                               rx_next = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                RX_PARITY: if (rx_sample) rx_next = RX_STOP;
                RX_STOP:   if (rx_sample) rx_next = RX_IDLE;
                default:   rx_next = RX_IDLE;
            endcase
        end
    end

    // The mid-bit counter restarts at each sample so later bits stay centred.
    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_os    <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_par   <= 1'b0;
        end else begin
            rx_s1    <= rx_in;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_state <= rx_next;
            if (rx_state == RX_IDLE) begin
                rx_os  <= '0;
                rx_bit <= '0;
            end else if (tick) begin
                rx_os <= rx_sample ? '0 : rx_os + 1'b1;
            end
            if (rx_sample && rx_state == RX_DATA) begin
                rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
            if (rx_sample && rx_state == RX_PARITY) rx_par <= rx_s2;
        end
    end

    always_ff @(posedge src_clk) begin
        if (!rst_n || cfg_mode) begin
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            if (stop_sample && !rx_s2)               frame_err   <= 1'b1;
            if (stop_sample && rx_s2 && !parity_ok)  parity_err  <= 1'b1;
            if (push_req && full && !pop)            rx_overflow <= 1'b1;
        end
    end

    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic [7:0]         rx_last;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign rx_count = count;

    always_ff @(posedge src_clk) begin
        if (push) mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rx_last <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                rx_last <= to_msg(rx_shift);
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    tx_state_t          tx_state, tx_next;
    logic [DIV_W-1:0]   tx_div;
    logic [OS_W-1:0]    tx_os;
    logic [BIT_W-1:0]   tx_bit;
    logic [DATA_W+1:0]  tx_frame, frame_in;
    logic [DATA_W-1:0]  load_word;
    logic [7:0]         tx_last;
    logic               load, tx_tick, bit_end, tx_done;

    assign pop       = (tx_state == TX_IDLE) && !cfg_mode && !stream && (count != '0);
    assign load      = pop || ((tx_state == TX_IDLE) && !cfg_mode && stream && send_pulse);
    assign load_word = stream ? manual_data : mem[rd_ptr];
    assign tx_tick   = (tx_div == div_max);
    assign bit_end   = tx_tick && (tx_os == OS_W'(OVERSAMPLE - 1));
    assign tx_done   = (tx_state == TX_BUSY) && bit_end && (tx_bit == BIT_W'(TX_BITS - 1));
    assign tx_busy   = (tx_state == TX_BUSY);

    // Frame beyond the start bit: data, then parity slot, then stop; unused slot stays 1.
    always_comb begin
        frame_in = '1;
        frame_in[DATA_W-1:0] = load_word;
        if (PARITY_EN != 0) frame_in[DATA_W] = (^load_word) ^ (PARITY_ODD != 0);
    end

    always_comb begin
        tx_next = tx_state;
        if (cfg_mode) begin
            tx_next = TX_IDLE;
        end else begin
            case (tx_state)
                TX_IDLE: if (load)    tx_next = TX_BUSY;
                TX_BUSY: if (tx_done) tx_next = TX_IDLE;
                default: tx_next = TX_IDLE;
            endcase
        end
    end

    // TX keeps its own divider phase so every bit lasts a full period from the load.
    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_out   <= 1'b1;
            tx_frame <= '1;
            tx_div   <= '0;
            tx_os    <= '0;
            tx_bit   <= '0;
            tx_last  <= '0;
        end else begin
            tx_state <= tx_next;
            if (cfg_mode) begin
                tx_out <= 1'b1;
            end else if (load) begin
                tx_frame <= frame_in;
                tx_out   <= 1'b0;
                tx_div   <= '0;
                tx_os    <= '0;
                tx_bit   <= '0;
                tx_last  <= to_msg(load_word);
            end else if (tx_state == TX_BUSY) begin
                if (!tx_tick) begin
                    tx_div <= tx_div + 1'b1;
                end else begin
                    tx_div <= '0;
                    if (!bit_end) begin
                        tx_os <= tx_os + 1'b1;
                    end else begin
                        tx_os <= '0;
                        if (tx_bit == BIT_W'(TX_BITS - 1)) begin
                            tx_out <= 1'b1;
                        end else begin
                            tx_out   <= tx_frame[0];
                            tx_frame <= {1'b1, tx_frame[DATA_W+1:1]};
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge src_clk) begin
        if (!rst_n)         msg <= 8'h00;
        else if (cfg_mode)  msg <= {6'b0, baud_sel};
        else if (!data_dir) msg <= rx_last;
        else if (stream)    msg <= to_msg(manual_data);
        else                msg <= tx_last;
    end

endmodule

// File: tb/tb_uart_bcd_bridge.sv
// Self-checking bench for uart_bcd_bridge: a plain and an even-parity instance driven with
// random UART frames, compared against a queue-based FIFO model and a bit-level TX decoder.
module tb_uart_bcd_bridge;

    localparam int CLK_HZ     = 1_843_200;
    localparam int DATA_W     = 8;
    localparam int OVERSAMPLE = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int SLOW_BIT   = 192;
    localparam int FAST_BIT   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, cfg_mode, data_dir, stream, send_pulse, rx_in, rx_in_p;
    logic [1:0]        baud_sel;
    logic [DATA_W-1:0] manual_data;
    logic              tx_out, tx_busy, rx_overflow, frame_err, parity_err;
    logic              tx_out_p, tx_busy_p, rx_overflow_p, frame_err_p, parity_err_p;
    logic [3:0]        rx_count, rx_count_p;
    logic [7:0]        msg, msg_p;

    uart_bcd_bridge #(.CLK_HZ(CLK_HZ), .DATA_W(DATA_W), .OVERSAMPLE(OVERSAMPLE),
                      .FIFO_DEPTH(FIFO_DEPTH), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .src_clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .baud_sel(baud_sel),
        .data_dir(data_dir), .stream(stream), .manual_data(manual_data),
        .send_pulse(send_pulse), .rx_in(rx_in), .tx_out(tx_out), .tx_busy(tx_busy),
        .rx_count(rx_count), .rx_overflow(rx_overflow), .frame_err(frame_err),
        .parity_err(parity_err), .msg(msg));

    uart_bcd_bridge #(.CLK_HZ(CLK_HZ), .DATA_W(DATA_W), .OVERSAMPLE(OVERSAMPLE),
                      .FIFO_DEPTH(FIFO_DEPTH), .PARITY_EN(1), .PARITY_ODD(0)) dutPar (
        .src_clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .baud_sel(baud_sel),
        .data_dir(data_dir), .stream(stream), .manual_data(manual_data),
        .send_pulse(send_pulse), .rx_in(rx_in_p), .tx_out(tx_out_p), .tx_busy(tx_busy_p),
        .rx_count(rx_count_p), .rx_overflow(rx_overflow_p), .frame_err(frame_err_p),
        .parity_err(parity_err_p), .msg(msg_p));

    int passCount = 0;
    int totalCount = 0;
    logic [7:0] fifoModel [$];
    logic [15:0] txFrame;
    int busyCycles;
    logic [7:0] word, lastWord;
    logic expOverflow;
    int extraBusy;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mkFrame(input logic [7:0] w, input logic stopBit);
        return {6'b0, stopBit, w, 1'b0};
    endfunction

    function automatic logic [15:0] mkParFrame(input logic [7:0] w, input logic parBit);
        return {5'b0, 1'b1, parBit, w, 1'b0};
    endfunction

    // Drives one serial frame, LSB first, onto the selected RX line; caller is at posedge+1.
    task automatic applyStimulus(input int which, input logic [15:0] bits, input int nbits, input int bitCyc);
        for (int i = 0; i < nbits; i++) begin
            if (which == 0) rx_in = bits[i];
            else            rx_in_p = bits[i];
            repeat (bitCyc) @(posedge clk);
            #1;
        end
        if (which == 0) rx_in = 1'b1;
        else            rx_in_p = 1'b1;
    endtask

    task automatic pulseSend();
        @(posedge clk); #1 send_pulse = 1'b1;
        @(posedge clk); #1 send_pulse = 1'b0;
    endtask

    // Waits for tx_busy, then samples tx_out at the middle of every bit period while busy.
    task automatic measureTx(input int bitCyc, input int nbits, input int timeout,
                             output logic [15:0] frame, output int cycles);
        int t;
        t = 0;
        frame = '0;
        cycles = 0;
        @(negedge clk);
        while (!tx_busy && t < timeout) begin
            @(negedge clk);
            t++;
        end
        if (!tx_busy) begin
            cycles = -1;
            return;
        end
        while (tx_busy && cycles < nbits * bitCyc + 100) begin
            if ((cycles % bitCyc) == bitCyc / 2 && (cycles / bitCyc) < 16)
                frame[cycles / bitCyc] = tx_out;
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_mode = 1'b0; baud_sel = 2'b00; data_dir = 1'b0; stream = 1'b1;
        manual_data = '0; send_pulse = 1'b0; rx_in = 1'b1; rx_in_p = 1'b1;
        waitCycles(3);
        checkOutput("reset_tx_out", tx_out, 1);
        checkOutput("reset_tx_busy", tx_busy, 0);
        checkOutput("reset_msg", msg, 0);
        checkOutput("reset_rx_count", rx_count, 0);
        checkOutput("reset_flags", {rx_overflow, frame_err, parity_err}, 0);
        rst_n = 1'b1;
        waitCycles(2);

        // Receive at 9600 with TX held idle.
        applyStimulus(0, mkFrame(8'hA5, 1'b1), 10, SLOW_BIT);
        waitCycles(4);
        checkOutput("rx1_count", rx_count, 1);
        checkOutput("rx1_msg", msg, 8'hA5);
        checkOutput("rx1_flags", {rx_overflow, frame_err, parity_err}, 0);

        // Loopback drains the buffered word, then echoes a fresh one.
        data_dir = 1'b1;
        stream = 1'b0;
        measureTx(SLOW_BIT, 10, 200, txFrame, busyCycles);
        checkOutput("drain_frame", txFrame, mkFrame(8'hA5, 1'b1));
        checkOutput("drain_busy", busyCycles, 10 * SLOW_BIT);
        checkOutput("drain_msg", msg, 8'hA5);
        checkOutput("drain_count", rx_count, 0);
        fork
            applyStimulus(0, mkFrame(8'h3C, 1'b1), 10, SLOW_BIT);
            measureTx(SLOW_BIT, 10, 4000, txFrame, busyCycles);
        join
        checkOutput("loop_frame", txFrame, mkFrame(8'h3C, 1'b1));
        checkOutput("loop_busy", busyCycles, 10 * SLOW_BIT);
        checkOutput("loop_count", rx_count, 0);
        checkOutput("loop_msg", msg, 8'h3C);

        // Configuration mode: display shows the selector, line idles high.
        cfg_mode = 1'b1;
        baud_sel = 2'b11;
        waitCycles(3);
        checkOutput("cfg_msg", msg, 8'h03);
        checkOutput("cfg_tx_out", tx_out, 1);
        cfg_mode = 1'b0;
        waitCycles(2);

        // Manual stream at 115200; a second pulse mid-frame must be ignored.
        stream = 1'b1;
        manual_data = 8'h41;
        waitCycles(2);
        checkOutput("manual_live_msg", msg, 8'h41);
        fork
            begin
                pulseSend();
                waitCycles(70);
                pulseSend();
            end
            measureTx(FAST_BIT, 10, 100, txFrame, busyCycles);
        join
        checkOutput("manual_frame", txFrame, mkFrame(8'h41, 1'b1));
        checkOutput("manual_busy", busyCycles, 10 * FAST_BIT);
        extraBusy = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_busy) extraBusy++;
        end
        checkOutput("no_second_frame", extraBusy, 0);
        for (int k = 0; k < 3; k++) begin
            word = 8'($urandom_range(0, 255));
            @(posedge clk); #1 manual_data = word;
            fork
                pulseSend();
                measureTx(FAST_BIT, 10, 100, txFrame, busyCycles);
            join
            checkOutput("manual_rand_frame", txFrame, mkFrame(word, 1'b1));
        end

        // Random loopback echoes.
        stream = 1'b0;
        for (int k = 0; k < 4; k++) begin
            word = 8'($urandom_range(0, 255));
            fork
                applyStimulus(0, mkFrame(word, 1'b1), 10, FAST_BIT);
                measureTx(FAST_BIT, 10, 400, txFrame, busyCycles);
            join
            checkOutput("loop_rand_frame", txFrame, mkFrame(word, 1'b1));
            checkOutput("loop_rand_busy", busyCycles, 10 * FAST_BIT);
        end
        waitCycles(2);
        checkOutput("loop_rand_count", rx_count, 0);

        // Overfill the FIFO with TX idle, then drain it in order.
        stream = 1'b1;
        data_dir = 1'b0;
        fifoModel.delete();
        expOverflow = 1'b0;
        for (int k = 0; k < FIFO_DEPTH + 1; k++) begin
            word = 8'($urandom_range(0, 255));
            applyStimulus(0, mkFrame(word, 1'b1), 10, FAST_BIT);
            if (fifoModel.size() < FIFO_DEPTH) fifoModel.push_back(word);
            else                               expOverflow = 1'b1;
        end
        waitCycles(4);
        checkOutput("fill_count", rx_count, fifoModel.size());
        checkOutput("fill_overflow", rx_overflow, expOverflow);
        checkOutput("fill_msg", msg, fifoModel[fifoModel.size() - 1]);
        cfg_mode = 1'b1;
        waitCycles(2);
        cfg_mode = 1'b0;
        waitCycles(2);
        checkOutput("cfg_clears_overflow", rx_overflow, 0);
        checkOutput("cfg_keeps_count", rx_count, FIFO_DEPTH);
        data_dir = 1'b1;
        stream = 1'b0;
        lastWord = 8'h00;
        while (fifoModel.size() > 0) begin
            lastWord = fifoModel.pop_front();
            measureTx(FAST_BIT, 10, 100, txFrame, busyCycles);
            checkOutput("drain_fifo_frame", txFrame, mkFrame(lastWord, 1'b1));
        end
        waitCycles(2);
        checkOutput("drain_fifo_count", rx_count, 0);
        checkOutput("drain_fifo_msg", msg, lastWord);

        // Framing and parity errors.
        stream = 1'b1;
        data_dir = 1'b0;
        applyStimulus(0, mkFrame(8'($urandom_range(0, 255)), 1'b0), 10, FAST_BIT);
        waitCycles(4);
        checkOutput("frame_err_set", frame_err, 1);
        checkOutput("frame_err_count", rx_count, 0);
        checkOutput("frame_err_parity", parity_err, 0);
        applyStimulus(1, mkParFrame(8'h07, 1'b0), 11, FAST_BIT);
        waitCycles(4);
        checkOutput("parity_err_set", parity_err_p, 1);
        checkOutput("parity_err_count", rx_count_p, 0);
        checkOutput("parity_err_frame", frame_err_p, 0);
        word = 8'($urandom_range(0, 255));
        applyStimulus(1, mkParFrame(word, ^word), 11, FAST_BIT);
        waitCycles(4);
        checkOutput("parity_ok_count", rx_count_p, 1);
        checkOutput("parity_ok_msg", msg_p, word);
        checkOutput("parity_sticky", parity_err_p, 1);

        // Reset in the middle of a transmission.
        applyStimulus(0, mkFrame(8'($urandom_range(0, 255)), 1'b1), 10, FAST_BIT);
        waitCycles(2);
        checkOutput("pre_reset_count", rx_count, 1);
        manual_data = 8'($urandom_range(0, 255));
        pulseSend();
        waitCycles(50);
        checkOutput("pre_reset_busy", tx_busy, 1);
        rst_n = 1'b0;
        waitCycles(1);
        checkOutput("mid_reset_tx_out", tx_out, 1);
        checkOutput("mid_reset_busy", tx_busy, 0);
        checkOutput("mid_reset_count", rx_count, 0);
        checkOutput("mid_reset_msg", msg, 0);
        checkOutput("mid_reset_flags", {rx_overflow, frame_err, parity_err}, 0);
        rst_n = 1'b1;
        waitCycles(2);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
